// File: rtl/ulpi_rx_decoder.sv
// ULPI receive decoder: splits the PHY bus into RX CMD status and a packet byte stream.
// Optional saturating packet/error counters are built when ULPI_RX_STATS_EN is defined.
module ulpi_rx_decoder #(
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ulpi_dir,
  input  logic                  ulpi_nxt,
  input  logic [7:0]            ulpi_rx_data,
  output logic                  rx_tvalid,
  input  logic                  rx_tready,
  output logic [7:0]            rx_tdata,
  output logic [1:0]            rx_tuser,
  output logic [1:0]            line_state,
  output logic [1:0]            vbus_state,
  output logic                  rx_active,
  output logic                  rx_error,
  output logic                  host_disconnect,
  output logic                  id,
  output logic                  update,
  output logic                  overflow
`ifdef ULPI_RX_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_pkt_count,
  output logic [STAT_WIDTH-1:0] stat_err_count
`endif
);

  logic       dir_q, synced_q, synced_d;
  logic       active_q, active_d, error_q, error_d;
  logic [1:0] line_q, line_d, vbus_q, vbus_d;
  logic       id_q, id_d, hdisc_q, hdisc_d;
  logic       update_q, update_d, overflow_q, overflow_d;
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       pkt_ovf_q, pkt_ovf_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [1:0] out_user_q, out_user_d;

  logic       turn, turn_rise, turn_fall, same_dir, is_data, is_cmd;
  logic       pkt_start, pkt_end;
  logic [1:0] rx_event;
  logic       emit, dropped;
  logic [7:0] emit_data;
  logic [1:0] emit_user;

  // Bus classification is suppressed until dir = 0 has been seen once after reset.
  always_comb begin
    rx_event  = ulpi_rx_data[5:4];
    turn      = synced_q & (ulpi_dir != dir_q);
    turn_rise = turn & ulpi_dir;
    turn_fall = turn & ~ulpi_dir;
    same_dir  = synced_q & ulpi_dir & dir_q;
    is_data   = same_dir & ulpi_nxt & active_q;
    is_cmd    = same_dir & ~ulpi_nxt;
    pkt_start = (turn_rise & ulpi_nxt) | (is_cmd & ~active_q & rx_event[0]);
    pkt_end   = (turn_fall & active_q) | (is_cmd & active_q & (rx_event == 2'b00));
  end

  always_comb begin
    synced_d = synced_q | ~ulpi_dir;
    active_d = active_q;
    error_d  = error_q;
    line_d   = line_q;
    vbus_d   = vbus_q;
    id_d     = id_q;
    hdisc_d  = hdisc_q;
    update_d = 1'b0;

    if (pkt_start) error_d = 1'b0;
    if (turn_rise && ulpi_nxt) active_d = 1'b1;
    if (turn_fall) active_d = 1'b0;

    if (is_cmd) begin
      line_d   = ulpi_rx_data[1:0];
      vbus_d   = ulpi_rx_data[3:2];
      id_d     = ulpi_rx_data[6];
      hdisc_d  = (rx_event == 2'b10);
      update_d = 1'b1;
      unique case (rx_event)
        2'b00: active_d = 1'b0;
        2'b01: active_d = 1'b1;
        2'b11: begin
          active_d = 1'b1;
          error_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One-byte holdback so the final byte of a packet can carry the end tag.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    emit         = 1'b0;
    emit_data    = hold_data_q;
    emit_user    = 2'b00;
    if (is_data) begin
      hold_valid_d = 1'b1;
      hold_data_d  = ulpi_rx_data;
      emit         = hold_valid_q;
    end else if (pkt_end) begin
      hold_valid_d = 1'b0;
      emit         = hold_valid_q;
      emit_user    = {error_q | pkt_ovf_q, 1'b1};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_user_d  = out_user_q;
    overflow_d  = 1'b0;
    pkt_ovf_d   = pkt_ovf_q;
    dropped     = 1'b0;

    if (pkt_start) pkt_ovf_d = 1'b0;

    if (out_valid_q && !rx_tready) begin
      if (emit) begin
        dropped   = 1'b1;
        pkt_ovf_d = 1'b1;
        // A lost end-of-packet is folded into the pending beat instead of vanishing.
        if (emit_user[0]) out_user_d = 2'b11;
        else              overflow_d = 1'b1;
      end
    end else begin
      out_valid_d = emit;
      if (emit) begin
        out_data_d = emit_data;
        out_user_d = emit_user;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q        <= 1'b0;
      synced_q     <= 1'b0;
      active_q     <= 1'b0;
      error_q      <= 1'b0;
      line_q       <= 2'b00;
      vbus_q       <= 2'b00;
      id_q         <= 1'b0;
      hdisc_q      <= 1'b0;
      update_q     <= 1'b0;
      overflow_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
      pkt_ovf_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_user_q   <= 2'b00;
    end else begin
      dir_q        <= ulpi_dir;
      synced_q     <= synced_d;
      active_q     <= active_d;
      error_q      <= error_d;
      line_q       <= line_d;
      vbus_q       <= vbus_d;
      id_q         <= id_d;
      hdisc_q      <= hdisc_d;
      update_q     <= update_d;
      overflow_q   <= overflow_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      pkt_ovf_q    <= pkt_ovf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_user_q   <= out_user_d;
    end
  end

  assign rx_tvalid       = out_valid_q;
  assign rx_tdata        = out_data_q;
  assign rx_tuser        = out_user_q;
  assign line_state      = line_q;
  assign vbus_state      = vbus_q;
  assign rx_active       = active_q;
  assign rx_error        = error_q;
  assign host_disconnect = hdisc_q;
  assign id              = id_q;
  assign update          = update_q;
  assign overflow        = overflow_q;

`ifdef ULPI_RX_STATS_EN
  logic [STAT_WIDTH-1:0] pkt_cnt_q, err_cnt_q;
  logic                  last_emit, last_err;

  always_comb begin
    last_emit = emit & emit_user[0];
    last_err  = last_emit & (emit_user[1] | dropped);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (last_emit && (pkt_cnt_q != '1)) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (last_err && (err_cnt_q != '1))  err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign stat_pkt_count = pkt_cnt_q;
  assign stat_err_count = err_cnt_q;
`else
  logic unused_dropped;
  assign unused_dropped = dropped;
`endif

endmodule

// File: tb/tb_ulpi_rx_decoder.sv
// Scoreboard bench for ulpi_rx_decoder: expected beats are queued as bytes are driven
// and popped when the stream hands them over.
module tb_ulpi_rx_decoder;

  localparam int unsigned StatWidth = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ulpi_dir = 1'b1;
  logic       ulpi_nxt = 1'b1;
  logic [7:0] ulpi_rx_data = 8'h00;
  logic       rx_tready = 1'b1;
  logic       rx_tvalid;
  logic [7:0] rx_tdata;
  logic [1:0] rx_tuser, line_state, vbus_state;
  logic       rx_active, rx_error, host_disconnect, id, update, overflow;
`ifdef ULPI_RX_STATS_EN
  logic [StatWidth-1:0] stat_pkt_count, stat_err_count;
`endif

  ulpi_rx_decoder #(.STAT_WIDTH(StatWidth)) dut (
    .clk             (clk),
    .rst             (rst),
    .ulpi_dir        (ulpi_dir),
    .ulpi_nxt        (ulpi_nxt),
    .ulpi_rx_data    (ulpi_rx_data),
    .rx_tvalid       (rx_tvalid),
    .rx_tready       (rx_tready),
    .rx_tdata        (rx_tdata),
    .rx_tuser        (rx_tuser),
    .line_state      (line_state),
    .vbus_state      (vbus_state),
    .rx_active       (rx_active),
    .rx_error        (rx_error),
    .host_disconnect (host_disconnect),
    .id              (id),
    .update          (update),
    .overflow        (overflow)
`ifdef ULPI_RX_STATS_EN
    ,
    .stat_pkt_count  (stat_pkt_count),
    .stat_err_count  (stat_err_count)
`endif
  );

  always #8 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned upd_cnt = 0;
  int unsigned ovf_cnt = 0;
  int unsigned exp_pkt = 0;
  int unsigned exp_errc = 0;
  logic [9:0]  sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic d, input logic n, input logic [7:0] b);
    ulpi_dir     = d;
    ulpi_nxt     = n;
    ulpi_rx_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] data, input logic [1:0] user);
    sb.push_back({user, data});
  endtask

  // Stream monitor and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (update)   upd_cnt++;
      if (overflow) ovf_cnt++;
      if (rx_tvalid && rx_tready) begin
        check_eq("beat_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check_eq("beat", {22'd0, rx_tuser, rx_tdata}, {22'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned u0;

    // Reset held with the PHY mid-packet.
    repeat (2) cyc(1'b1, 1'b1, 8'h77);
    check_eq("rst_tvalid", 32'(rx_tvalid), 0);
    check_eq("rst_status", {24'd0, line_state, vbus_state, rx_active, rx_error, host_disconnect, id},
             0);
    check_eq("rst_pulses", {30'd0, update, overflow}, 0);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 8'hA5);
    cyc(1'b1, 1'b1, 8'h5A);
    cyc(1'b1, 1'b0, 8'h4D);
    check_eq("unsync_cmd_ignored", {30'd0, line_state}, 0);
    check_eq("unsync_active", 32'(rx_active), 0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Normal packet C3 01 02 closed by RX CMD 0x01, followed by RX CMD 0x00.
    u0 = upd_cnt;
    cyc(1'b1, 1'b1, 8'hEE);
    check_eq("pkt_active_rise", 32'(rx_active), 1);
    push(8'hC3, 2'b00); push(8'h01, 2'b00); push(8'h02, 2'b01);
    cyc(1'b1, 1'b1, 8'hC3);
    cyc(1'b1, 1'b1, 8'h01);
    cyc(1'b1, 1'b1, 8'h02);
    cyc(1'b1, 1'b0, 8'h01);
    check_eq("pkt_active_fall", 32'(rx_active), 0);
    check_eq("pkt_update", 32'(update), 1);
    exp_pkt++;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("pkt_update_count", upd_cnt - u0, 2);

    // RX CMD 0x4D while idle, then host-disconnect set and clear.
    cyc(1'b1, 1'b0, 8'h00);
    u0 = upd_cnt;
    cyc(1'b1, 1'b0, 8'h4D);
    check_eq("cmd_fields", {25'd0, line_state, vbus_state, id, rx_active, host_disconnect},
             {25'd0, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0});
    check_eq("cmd_update", 32'(update), 1);
    cyc(1'b1, 1'b0, 8'h20);
    check_eq("hdisc_set", 32'(host_disconnect), 1);
    cyc(1'b1, 1'b0, 8'h4D);
    check_eq("hdisc_clear", 32'(host_disconnect), 0);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("cmd_update_low", 32'(update), 0);
    check_eq("cmd_update_count", upd_cnt - u0, 3);

    // Error packet: 69 12, RxEvent 11, then dir falls.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h00);
    push(8'h69, 2'b00); push(8'h12, 2'b11);
    cyc(1'b1, 1'b1, 8'h69);
    cyc(1'b1, 1'b1, 8'h12);
    cyc(1'b1, 1'b0, 8'h31);
    check_eq("err_set", {30'd0, rx_active, rx_error}, 32'b11);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("err_dir_fall", {30'd0, rx_active, rx_error}, 32'b01);
    exp_pkt++; exp_errc++;
    cyc(1'b0, 1'b0, 8'h00);

    // Backpressure across a 4-byte packet.
    rx_tready = 1'b0;
    u0 = ovf_cnt;
    cyc(1'b1, 1'b1, 8'h00);
    check_eq("err_cleared_on_start", 32'(rx_error), 0);
    push(8'hB0, 2'b11);
    cyc(1'b1, 1'b1, 8'hB0);
    cyc(1'b1, 1'b1, 8'hB1);
    cyc(1'b1, 1'b1, 8'hB2);
    check_eq("bp_first_beat", {23'd0, rx_tvalid, rx_tdata}, {23'd0, 1'b1, 8'hB0});
    cyc(1'b1, 1'b1, 8'hB3);
    cyc(1'b0, 1'b0, 8'h00);
    exp_pkt++; exp_errc++;
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("bp_held", {21'd0, rx_tvalid, rx_tuser, rx_tdata}, {21'd0, 1'b1, 2'b11, 8'hB0});
    check_eq("bp_overflow_count", ovf_cnt - u0, 2);
    rx_tready = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_eq("bp_drained", 32'(rx_tvalid), 0);

    // RxEvent 01 immediately followed by dir falling, no data.
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h10);
    check_eq("empty_active", 32'(rx_active), 1);
    cyc(1'b0, 1'b0, 8'h00);
    check_eq("empty_active_fall", 32'(rx_active), 0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_eq("empty_no_beat", 32'(rx_tvalid), 0);

`ifdef ULPI_RX_STATS_EN
    check_eq("stat_pkt", 32'(stat_pkt_count), exp_pkt);
    check_eq("stat_err", 32'(stat_err_count), exp_errc);
`endif
    check_eq("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
